// File: rtl/float_recip_nr.sv
// Floating-point reciprocal using Newton-Raphson refinement of a linear seed on a fixed-point
// mantissa datapath, with valid/ready handshakes, special-value decode and IEEE-style flags.
module float_recip_nr #(
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned MAN_W    = 23,
  parameter int unsigned GUARD    = 4,
  parameter int unsigned MAX_ITER = 3,
  localparam int unsigned DATA_W  = 1 + EXP_W + MAN_W
) (
  input  logic              clk_p,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_flags,
  output logic [2:0]        out_iters
);

  // F fractional bits, two integer bits so X = 2.0 is representable.
  localparam int unsigned F    = MAN_W + 1 + GUARD;
  localparam int unsigned W    = F + 2;
  localparam int unsigned CW   = W + 8;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic [CW-1:0] C48_WIDE = ((CW'(48) << F) + CW'(8)) / CW'(17);
  localparam logic [CW-1:0] C32_WIDE = ((CW'(32) << F) + CW'(8)) / CW'(17);
  localparam logic [W-1:0]  C48      = C48_WIDE[W-1:0];
  localparam logic [W-1:0]  C32      = C32_WIDE[W-1:0];
  localparam logic [W-1:0]  TWO      = {2'b10, {F{1'b0}}};
  localparam logic [EXP_W+1:0] E_BASE = (EXP_W + 2)'(2 * BIAS - 1);

  typedef enum logic [2:0] {
    StIdle, StClassify, StSpecial, StMulA, StMulB, StNorm, StDone
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] op_q;
  logic [W-1:0]      d_q, x_q, t_q;
  logic [2:0]        iter_q;
  logic [DATA_W-1:0] out_data_q;
  logic [3:0]        out_flags_q;
  logic [2:0]        out_iters_q;

  function automatic logic [W-1:0] mul_fix(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(p >> F);
  endfunction

  logic             op_sign;
  logic [EXP_W-1:0] op_exp;
  logic [MAN_W-1:0] op_man;
  logic             exp_ones, exp_zero, man_zero, is_special;

  assign op_sign    = op_q[DATA_W-1];
  assign op_exp     = op_q[DATA_W-2:MAN_W];
  assign op_man     = op_q[MAN_W-1:0];
  assign exp_ones   = &op_exp;
  assign exp_zero   = ~|op_exp;
  assign man_zero   = ~|op_man;
  assign is_special = exp_ones | exp_zero;

  logic [W-1:0] d_seed, x_seed, t_new, x_new;
  logic [2:0]   iter_inc;
  logic         last_iter;

  assign d_seed    = {2'b00, 1'b1, op_man, {GUARD{1'b0}}};
  assign x_seed    = C48 - mul_fix(C32, d_seed);
  assign t_new     = mul_fix(d_q, x_q);
  assign x_new     = mul_fix(x_q, TWO - t_q);
  assign iter_inc  = iter_q + 3'd1;
  assign last_iter = (iter_inc == 3'(MAX_ITER)) || (x_new == x_q);

  logic [DATA_W-1:0] spec_data;
  logic [3:0]        spec_flags;

  always_comb begin
    spec_data  = {op_sign, {(EXP_W + MAN_W){1'b0}}};
    spec_flags = 4'b0000;
    if (exp_ones && !man_zero) begin
      spec_data  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
      spec_flags = 4'b1000;
    end else if (exp_zero) begin
      spec_data  = {op_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags = 4'b0100;
    end
  end

  // Round X to MAN_W fraction bits; a carry into the integer bit means the result is 2.0.
  logic [MAN_W:0]    frac_rnd;
  logic              round_up, sticky, ovf, uf, n_inexact;
  logic [EXP_W+1:0]  e_res;
  logic [MAN_W-1:0]  n_man;
  logic [DATA_W-1:0] norm_data;
  logic [3:0]        norm_flags;

  always_comb begin
    sticky     = |x_q[GUARD-1:0];
    round_up   = x_q[GUARD] & (sticky | x_q[GUARD+1]);
    frac_rnd   = {1'b0, x_q[F-1:F-MAN_W]} + {{MAN_W{1'b0}}, round_up};
    ovf        = x_q[F+1] | (x_q[F] & frac_rnd[MAN_W]);
    e_res      = E_BASE - {2'b00, op_exp} + {{(EXP_W + 1){1'b0}}, man_zero | ovf};
    uf         = e_res[EXP_W+1] | (e_res == '0);
    n_man      = (man_zero | ovf) ? '0 : frac_rnd[MAN_W-1:0];
    n_inexact  = man_zero ? 1'b0 : |x_q[GUARD:0];
    norm_data  = uf ? {op_sign, {(EXP_W + MAN_W){1'b0}}} : {op_sign, e_res[EXP_W-1:0], n_man};
    norm_flags = {2'b00, uf, uf | n_inexact};
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (in_valid) state_d = StClassify;
      StClassify: state_d = is_special ? StSpecial : StMulA;
      StSpecial:  state_d = StDone;
      StMulA:     state_d = StMulB;
      StMulB:     state_d = last_iter ? StNorm : StMulA;
      StNorm:     state_d = StDone;
      StDone:     if (out_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      d_q         <= '0;
      x_q         <= '0;
      t_q         <= '0;
      iter_q      <= '0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      out_iters_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (in_valid) op_q <= in_data;
        StClassify: begin
          d_q    <= d_seed;
          x_q    <= x_seed;
          iter_q <= '0;
        end
        StMulA: t_q <= t_new;
        StMulB: begin
          x_q    <= x_new;
          iter_q <= iter_inc;
        end
        StSpecial: begin
          out_data_q  <= spec_data;
          out_flags_q <= spec_flags;
          out_iters_q <= '0;
        end
        StNorm: begin
          out_data_q  <= norm_data;
          out_flags_q <= norm_flags;
          out_iters_q <= iter_q;
        end
        default: ;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;
  assign out_iters = out_iters_q;

endmodule

// File: tb/tb_float_recip_nr.sv
// Scoreboard bench for float_recip_nr: the driver queues expected results, a monitor checks
// each handshaken output for value, flags, iteration count and latency.
module tb_float_recip_nr;

  logic        clk_p = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [2:0]  out_iters;

  float_recip_nr #(
    .EXP_W   (8),
    .MAN_W   (23),
    .GUARD   (4),
    .MAX_ITER(3)
  ) dut (
    .clk_p    (clk_p),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_flags(out_flags),
    .out_iters(out_iters)
  );

  always #5 clk_p = ~clk_p;

  typedef struct {
    logic [31:0] din;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [3:0]  fl;
    bit          spec;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk_p) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic send(input logic [31:0] din, input logic [31:0] e0, input logic [31:0] e1,
                      input logic [3:0] fl, input bit spec);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout operand=%h in_ready=%b required=1", din, in_ready);
      return;
    end
    in_valid = 1'b1;
    in_data  = din;
    sb.push_back('{din, e0, e1, fl, spec, cyc});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: sampled on the falling edge, compares on every handshake.
  exp_t e;
  bit   seen = 0;
  int   vcyc = 0;
  initial begin
    forever begin
      @(negedge clk_p);
      if (!rst_n) begin
        seen = 0;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1;
          vcyc = cyc;
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output actual=%h required=none", out_data);
          end else begin
            e = sb.pop_front();
            total++;
            if (out_data !== e.e0 && out_data !== e.e1) begin
              bad++;
              $display("FAIL data_%h actual=%h required=%h or %h", e.din, out_data, e.e0, e.e1);
            end
            chk($sformatf("flags_%h", e.din), 64'(out_flags), 64'(e.fl));
            if (e.spec) begin
              chk($sformatf("iters_%h", e.din), 64'(out_iters), 64'd0);
              chk($sformatf("latency_%h", e.din), 64'(vcyc - e.acc), 64'd3);
            end else begin
              chk($sformatf("iters_range_%h", e.din),
                  64'(out_iters >= 3'd1 && out_iters <= 3'd3), 64'd1);
              chk($sformatf("latency_%h", e.din), 64'(vcyc - e.acc),
                  64'(3 + 2 * int'(out_iters)));
            end
          end
          seen = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_out_iters", 64'(out_iters), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    send(32'h4000_0000, 32'h3F00_0000, 32'h3F00_0000, 4'b0000, 1'b0);
    send(32'h4040_0000, 32'h3EAA_AAAB, 32'h3EAA_AAAA, 4'b0001, 1'b0);
    send(32'h3FC0_0000, 32'h3F2A_AAAB, 32'h3F2A_AAAA, 4'b0001, 1'b0);
    send(32'h40A0_0000, 32'h3E4C_CCCD, 32'h3E4C_CCCC, 4'b0001, 1'b0);
    send(32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000, 4'b0100, 1'b1);
    send(32'h8000_0000, 32'hFF80_0000, 32'hFF80_0000, 4'b0100, 1'b1);
    send(32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b1);
    send(32'h7FC0_0001, 32'h7FC0_0000, 32'h7FC0_0000, 4'b1000, 1'b1);
    send(32'h7F00_0000, 32'h0000_0000, 32'h0000_0000, 4'b0011, 1'b0);
    drain();

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    send(32'hC080_0000, 32'hBE80_0000, 32'hBE80_0000, 4'b0000, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("hold_reached_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold_valid_%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("hold_data_%0d", i), 64'(out_data), 64'hBE80_0000);
      chk($sformatf("hold_flags_%0d", i), 64'(out_flags), 64'd0);
      chk($sformatf("hold_in_ready_%0d", i), 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("release_in_ready", 64'(in_ready), 64'd1);
    send(32'h3F00_0000, 32'h4000_0000, 32'h4000_0000, 4'b0000, 1'b0);
    drain();

    // Reset while the first MUL_B is executing.
    send(32'h4040_0000, 32'h3EAA_AAAB, 32'h3EAA_AAAA, 4'b0001, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
